// File: rtl/burst_rom_reader.sv
// burst_rom_reader: streams bursts of words from a fixed 8-entry-pattern ROM with ready/valid, abort and err/done pulses; optional dout_parity via ROM_PARITY_EN
module burst_rom_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef ROM_PARITY_EN
  ,
  output logic                  dout_parity
`endif
);
  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;
  localparam logic [63:0] table_bits = 64'hAAF00FCCE718B7ED;
  localparam logic [ADDR_WIDTH:0] depth = {1'b1, {ADDR_WIDTH{1'b0}}};
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0] cnt;
  logic ok, hs, last;
  function automatic logic [DATA_WIDTH-1:0] rom(input logic [ADDR_WIDTH-1:0] a);
    logic [2:0] i;
    i = 3'(a);
    return DATA_WIDTH'(table_bits[{i, 3'b000} +: 8]);
  endfunction
  assign ok = start && len != '0 && len <= depth;
  assign hs = state == STREAM && dout_ready;
  assign last = cnt == (ADDR_WIDTH+1)'(1);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      addr <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      err <= state == IDLE && start && !ok;
      if (state == IDLE && ok) begin
        addr <= base_addr;
        cnt <= len;
      end else if (hs && !abort) begin
        addr <= addr + 1'b1;
        cnt <= cnt - 1'b1;
      end
    end
  end
  // abort outranks a handshake landing on the same edge
  always_comb begin
    state_nx = state == IDLE ? (ok ? STREAM : IDLE) :
               state == STREAM ? (abort ? IDLE : (hs && last ? FINISH : STREAM)) : IDLE;
  end
  always_comb begin
    dout_valid = state == STREAM;
    busy = state == STREAM;
    done = state == FINISH;
    dout = dout_valid ? rom(addr) : '0;
`ifdef ROM_PARITY_EN
    dout_parity = ^dout;
`endif
  end
endmodule
